// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Contents: FSM state encoding, operation encoding, default operand width and iteration count.
// Configuration macro used by the unit: MDU_UNSIGNED_EN (adds MULTU/DIVU support).
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    // One shift-add / shift-subtract iteration per operand bit.
    localparam int MDU_ITER  = MDU_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } mdu_op_t;

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate; yields |x| when neg is the sign bit, or -x on request.
// Ports: din (W bits), neg (1 = negate), dout (W bits). Purely combinational.
// Used for operand magnitudes at accept and for the sign fix-up of results.
module mdu_abs_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);

    assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/DIV unit holding HI/LO; done pulses WIDTH+2 cycles after an accepted start
// (1 cycle for divide-by-zero). busy is high in RUN/FIX and starts seen while busy or in DONE are dropped.
// Ports: clk, reset_n, start_mult, start_div, [op_unsigned], a_in, b_in -> busy, done, div_zero, hi_out, lo_out.
// Macro MDU_UNSIGNED_EN adds the op_unsigned port for MULTU/DIVU; without it every op is signed.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_mult,
    input  logic             start_div,
`ifdef MDU_UNSIGNED_EN
    input  logic             op_unsigned,
`endif
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mdu_state_t         state, state_nxt;
    mdu_op_t            op_q, op_sel;
    logic               neg_res_q;      // sign(a) ^ sign(b): product / quotient sign
    logic               neg_rem_q;      // sign(a): remainder sign
    logic [WIDTH-1:0]   opnd_q;         // |multiplicand| or |divisor|
    logic [2*WIDTH-1:0] acc_q;          // mult: {partial product, multiplier}; div: low half = dividend -> quotient
    logic [WIDTH:0]     rem_q;          // restoring-division partial remainder
    logic [CNT_W-1:0]   cnt_q;

    logic               is_signed, a_neg, b_neg, accept, dz;
    logic [WIDTH-1:0]   abs_a, abs_b, quot_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix, mult_nxt;
    logic [WIDTH:0]     mult_sum;
    logic [WIDTH+1:0]   div_shift, div_dvsr;
    logic               div_take;

`ifdef MDU_UNSIGNED_EN
    assign is_signed = ~op_unsigned;
`else
    assign is_signed = 1'b1;
`endif

    assign a_neg  = is_signed & a_in[WIDTH-1];
    assign b_neg  = is_signed & b_in[WIDTH-1];
    assign op_sel = start_mult ? OP_MULT : OP_DIV;   // simultaneous starts: mult wins
    assign accept = (state == IDLE) && (start_mult || start_div);
    assign dz     = (op_sel == OP_DIV) && (b_in == '0);

    mdu_abs_neg #(.W(WIDTH))   u_abs_a (.din(a_in),              .neg(a_neg),     .dout(abs_a));
    mdu_abs_neg #(.W(WIDTH))   u_abs_b (.din(b_in),              .neg(b_neg),     .dout(abs_b));
    mdu_abs_neg #(.W(2*WIDTH)) u_fix_p (.din(acc_q),             .neg(neg_res_q), .dout(prod_fix));
    mdu_abs_neg #(.W(WIDTH))   u_fix_q (.din(acc_q[WIDTH-1:0]),  .neg(neg_res_q), .dout(quot_fix));
    mdu_abs_neg #(.W(WIDTH))   u_fix_r (.din(rem_q[WIDTH-1:0]),  .neg(neg_rem_q), .dout(rem_fix));

    // Shift-add step: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
    assign mult_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mult_nxt = {mult_sum, acc_q[WIDTH-1:1]};

    // Restoring step: bring in the next dividend bit, subtract the divisor if it fits.
    assign div_shift = {rem_q, acc_q[WIDTH-1]};
    assign div_dvsr  = {2'b00, opnd_q};
    assign div_take  = (div_shift >= div_dvsr);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = dz ? DONE : RUN;
            RUN: begin
                busy = 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            op_q      <= OP_MULT;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            div_zero  <= 1'b0;
            hi_out    <= '0;
            lo_out    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    op_q      <= op_sel;
                    neg_res_q <= a_neg ^ b_neg;
                    neg_rem_q <= a_neg;
                    cnt_q     <= '0;
                    rem_q     <= '0;
                    div_zero  <= dz;
                    if (op_sel == OP_MULT) begin
                        opnd_q <= abs_a;
                        acc_q  <= {{WIDTH{1'b0}}, abs_b};
                    end else begin
                        opnd_q <= abs_b;
                        acc_q  <= {{WIDTH{1'b0}}, abs_a};
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (op_q == OP_MULT) begin
                        acc_q <= mult_nxt;
                    end else begin
                        rem_q             <= div_take ? (WIDTH+1)'(div_shift - div_dvsr)
                                                      : div_shift[WIDTH:0];
                        acc_q[WIDTH-1:0]  <= {acc_q[WIDTH-2:0], div_take};
                    end
                end
                FIX: begin
                    if (op_q == OP_MULT) begin
                        hi_out <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_out <= prod_fix[WIDTH-1:0];
                    end else begin
                        hi_out <= rem_fix;
                        lo_out <= quot_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: MULT/DIV signs, latency, divide-by-zero,
// overflow case, ignored starts, mid-op reset, and MULTU/DIVU when MDU_UNSIGNED_EN is defined.
// Ends with a single summary line of vectors applied and miscompares.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi_out, lo_out;
`ifdef MDU_UNSIGNED_EN
    logic        op_unsigned = 1'b0;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_mult (start_mult),
        .start_div  (start_div),
`ifdef MDU_UNSIGNED_EN
        .op_unsigned(op_unsigned),
`endif
        .a_in       (a_in),
        .b_in       (b_in),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issue one op; returns in the cycle done is seen (lat = cycle number, -1 on timeout).
    // poke > 0 pulses start_div during that cycle of the op.
    task automatic run_op(input bit mul, input logic [31:0] a, input logic [31:0] b,
                          input int poke, output int lat, output int idle_gaps);
        @(negedge clk);
        start_mult = mul;
        start_div  = !mul;
        a_in       = a;
        b_in       = b;
        @(posedge clk); #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a_in       = 32'hDEAD_BEEF;
        b_in       = 32'h0;
        lat        = -1;
        idle_gaps  = 0;
        for (int n = 1; n <= 60; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            if (!busy) idle_gaps++;
            start_div = (n == poke);
            @(posedge clk); #1;
        end
        start_div = 1'b0;
    endtask

    task automatic to_idle();
        @(posedge clk); #1;
    endtask

    int lat, gaps, dones;

    initial begin
        // Reset state
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_divz", div_zero, 0);
        check("rst_hi",   hi_out, 0);
        check("rst_lo",   lo_out, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // 1. 7 * -3
        run_op(1'b1, 32'd7, 32'hFFFF_FFFD, 0, lat, gaps);
        check("mul_lat",     lat, 34);
        check("mul_busy",    gaps, 0);
        check("mul_busy_dn", busy, 0);
        check("mul_hi",      hi_out, 32'hFFFF_FFFF);
        check("mul_lo",      lo_out, 32'hFFFF_FFEB);
        // A start presented in the DONE cycle must be dropped.
        start_mult = 1'b1;
        a_in = 32'd1;
        b_in = 32'd1;
        @(posedge clk); #1;
        start_mult = 1'b0;
        check("start_in_done", busy, 0);
        to_idle();
        check("start_in_done2", busy, 0);

        // 2. 100/7 and -100/7
        run_op(1'b0, 32'd100, 32'd7, 0, lat, gaps);
        check("div_lat", lat, 34);
        check("div_lo",  lo_out, 32'd14);
        check("div_hi",  hi_out, 32'd2);
        to_idle();
        run_op(1'b0, 32'hFFFF_FF9C, 32'd7, 0, lat, gaps);
        check("sdiv_lo", lo_out, 32'hFFFF_FFF2);
        check("sdiv_hi", hi_out, 32'hFFFF_FFFE);
        check("sdiv_dz", div_zero, 0);
        to_idle();

        // 3. divide by zero keeps prior HI/LO
        run_op(1'b0, 32'd55, 32'd0, 0, lat, gaps);
        check("dz_lat",  lat, 1);
        check("dz_flag", div_zero, 1);
        check("dz_lo",   lo_out, 32'hFFFF_FFF2);
        check("dz_hi",   hi_out, 32'hFFFF_FFFE);
        to_idle();
        check("dz_sticky", div_zero, 1);

        // 4. most-negative / -1
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, gaps);
        check("ovf_lat", lat, 34);
        check("ovf_lo",  lo_out, 32'h8000_0000);
        check("ovf_hi",  hi_out, 32'h0);
        check("ovf_dz",  div_zero, 0);
        to_idle();

        // 5. start_div while busy is ignored
        run_op(1'b1, 32'h0001_2345, 32'h0000_0100, 5, lat, gaps);
        check("poke_lat", lat, 34);
        check("poke_lo",  lo_out, 32'h0123_4500);
        check("poke_hi",  hi_out, 32'h0);
        check("poke_dz",  div_zero, 0);
        to_idle();

        // reset in cycle 10 of an op
        @(negedge clk);
        start_mult = 1'b1;
        a_in = 32'd5;
        b_in = 32'd5;
        @(posedge clk); #1;
        start_mult = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("mid_busy_pre", busy, 1);
        reset_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_hi",   hi_out, 0);
        check("mid_lo",   lo_out, 0);
        check("mid_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("mid_no_done", dones, 0);
        check("mid_idle",    busy, 0);

`ifdef MDU_UNSIGNED_EN
        // 6. unsigned ops
        op_unsigned = 1'b1;
        run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, gaps);
        check("multu_hi", hi_out, 32'hFFFF_FFFE);
        check("multu_lo", lo_out, 32'h0000_0001);
        to_idle();
        run_op(1'b0, 32'hFFFF_FFFF, 32'd2, 0, lat, gaps);
        check("divu_lo", lo_out, 32'h7FFF_FFFF);
        check("divu_hi", hi_out, 32'h0000_0001);
        to_idle();
        op_unsigned = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
